// File: rtl/sqrt_shift_reg.sv
// sqrt_shift_reg: radicand/remainder shift register for the iterative square-root datapath.
// State updates on the falling edge of clk. The control FSM drives its commands from the
// rising edge, so the commands have half a cycle to settle.
//
// Ports:
//   clk      clock, state updates on the falling edge
//   reset    asynchronous active-low reset
//   in_A     parallel load operand
//   load     load in_A, clear out_msb and restart the iteration count
//   shift    shift left by STEP with zero fill (ignored once done)
//   load_R0  write in_bit into bit 0 (after any shift on the same edge)
//   in_bit   comparator result bit
//   out_r    register contents
//   out_msb  bits shifted out by the most recent accepted shift
//   count    accepted shifts since the last load
//   done     count == ITER
module sqrt_shift_reg #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned STEP  = 2,
    parameter int unsigned ITER  = WIDTH / STEP,
    parameter int unsigned CW    = $clog2(ITER + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_A,
    input  logic             load,
    input  logic             shift,
    input  logic             load_R0,
    input  logic             in_bit,
    output logic [WIDTH-1:0] out_r,
    output logic [STEP-1:0]  out_msb,
    output logic [CW-1:0]    count,
    output logic             done
);

    logic [WIDTH-1:0] r_q, r_d;
    logic [STEP-1:0]  msb_q, msb_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shifted;
    logic             done_int;
    logic             shift_ok;

    assign shifted  = {r_q[WIDTH-1-STEP:0], {STEP{1'b0}}};
    // Decoded from the registered count only, so it cannot glitch between edges.
    assign done_int = (count_q == CW'(ITER));
    // Saturate: a shift after the last iteration must not move anything.
    assign shift_ok = shift && !done_int;

    always_comb begin
        r_d     = r_q;
        msb_d   = msb_q;
        count_d = count_q;
        if (load) begin
            r_d     = in_A;
            msb_d   = '0;
            count_d = '0;
        end else begin
            if (shift_ok) begin
                r_d     = shifted;
                msb_d   = r_q[WIDTH-1 -: STEP];
                count_d = count_q + CW'(1);
            end
            // Bit 0 override applies on top of the shift result, or alone.
            if (load_R0) begin
                r_d[0] = in_bit;
            end
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_q     <= '0;
            msb_q   <= '0;
            count_q <= '0;
        end else begin
            r_q     <= r_d;
            msb_q   <= msb_d;
            count_q <= count_d;
        end
    end

    assign out_r   = r_q;
    assign out_msb = msb_q;
    assign count   = count_q;
    assign done    = done_int;

endmodule

// File: tb/tb_sqrt_shift_reg.sv
module tb_sqrt_shift_reg;

    logic        clk;
    logic        reset;

    // WIDTH=16, STEP=2 instance
    logic [15:0] a;
    logic        ld, sh, r0, ib;
    logic [15:0] out_r;
    logic [1:0]  out_msb;
    logic [3:0]  count;
    logic        done;

    // WIDTH=16, STEP=1 instance
    logic [15:0] a1;
    logic        ld1, sh1;
    logic [15:0] out_r1;
    logic [0:0]  out_msb1;
    logic [4:0]  count1;
    logic        done1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [15:0] r;
        logic [1:0]  msb;
        logic [3:0]  cnt;
        logic        dn;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_r;
    logic [1:0]  m_msb;
    logic [3:0]  m_cnt;

    sqrt_shift_reg #(.WIDTH(16), .STEP(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .in_A   (a),
        .load   (ld),
        .shift  (sh),
        .load_R0(r0),
        .in_bit (ib),
        .out_r  (out_r),
        .out_msb(out_msb),
        .count  (count),
        .done   (done)
    );

    sqrt_shift_reg #(.WIDTH(16), .STEP(1)) dut1 (
        .clk    (clk),
        .reset  (reset),
        .in_A   (a1),
        .load   (ld1),
        .shift  (sh1),
        .load_R0(1'b0),
        .in_bit (1'b0),
        .out_r  (out_r1),
        .out_msb(out_msb1),
        .count  (count1),
        .done   (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive one command set from the rising edge, predict, then compare after the falling edge.
    task automatic cycle(input string tag, input logic l, input logic s, input logic z,
                         input logic b, input logic [15:0] d);
        exp_t e;
        exp_t o;
        @(posedge clk);
        ld = l; sh = s; r0 = z; ib = b; a = d;
        if (l) begin
            m_r = d; m_msb = 2'b00; m_cnt = 4'd0;
        end else begin
            if (s && m_cnt != 4'd8) begin
                m_msb = m_r[15:14];
                m_r   = {m_r[13:0], 2'b00};
                m_cnt = m_cnt + 4'd1;
            end
            if (z) m_r[0] = b;
        end
        e.r = m_r; e.msb = m_msb; e.cnt = m_cnt; e.dn = (m_cnt == 4'd8);
        sb.push_back(e);
        @(negedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, " sb_empty"}, 32'd0, 32'd1);
        end else begin
            o = sb.pop_front();
            check({tag, " out_r"},   32'(out_r),   32'(o.r));
            check({tag, " out_msb"}, 32'(out_msb), 32'(o.msb));
            check({tag, " count"},   32'(count),   32'(o.cnt));
            check({tag, " done"},    32'(done),    32'(o.dn));
        end
    endtask

    task automatic cycle1(input logic l, input logic s, input logic [15:0] d);
        @(posedge clk);
        ld1 = l; sh1 = s; a1 = d;
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        a = '0; ld = 0; sh = 0; r0 = 0; ib = 0;
        a1 = '0; ld1 = 0; sh1 = 0;
        m_r = '0; m_msb = '0; m_cnt = '0;
        #12;
        check("reset out_r", 32'(out_r), 32'h0);
        check("reset out_msb", 32'(out_msb), 32'h0);
        check("reset count", 32'(count), 32'h0);
        check("reset done", 32'(done), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Load then shift, then shift with bit-0 override
        cycle("ld B5A3", 1, 0, 0, 0, 16'hB5A3);
        cycle("sh1", 0, 1, 0, 0, 16'h0);
        check("sh1 vec r", 32'(out_r), 32'hD68C);
        check("sh1 vec msb", 32'(out_msb), 32'h2);
        cycle("sh+r0", 0, 1, 1, 1, 16'h0);
        check("sh+r0 vec r", 32'(out_r), 32'h5A31);
        check("sh+r0 vec msb", 32'(out_msb), 32'h3);
        check("sh+r0 vec cnt", 32'(count), 32'd2);
        cycle("idle", 0, 0, 0, 0, 16'h0);

        // Full run to done, then saturation
        cycle("ld FFFF", 1, 0, 0, 0, 16'hFFFF);
        for (int i = 0; i < 8; i++) cycle("run", 0, 1, 0, 0, 16'h0);
        check("run8 r", 32'(out_r), 32'h0);
        check("run8 msb", 32'(out_msb), 32'h3);
        check("run8 done", 32'(done), 32'h1);
        cycle("sh9", 0, 1, 0, 0, 16'h0);
        check("sh9 cnt", 32'(count), 32'd8);
        cycle("done sh+r0", 0, 1, 1, 1, 16'h0);
        check("done sh+r0 r", 32'(out_r), 32'h1);
        cycle("reload", 1, 0, 0, 0, 16'h1234);
        check("reload done", 32'(done), 32'h0);

        // Load wins over shift and load_R0
        cycle("ld+sh", 1, 1, 1, 1, 16'h1234);
        check("ld+sh r", 32'(out_r), 32'h1234);

        // load_R0 alone
        cycle("ld 00F0", 1, 0, 0, 0, 16'h00F0);
        cycle("r0=1", 0, 0, 1, 1, 16'h0);
        check("r0=1 r", 32'(out_r), 32'h00F1);
        cycle("r0=0", 0, 0, 1, 0, 16'h0);
        check("r0=0 r", 32'(out_r), 32'h00F0);

        // Mixed random traffic against the model
        for (int i = 0; i < 40; i++) begin
            cycle("rand", ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1), 16'($urandom));
        end

        // Asynchronous reset mid-operation
        cycle("ld A5A5", 1, 0, 0, 0, 16'hA5A5);
        for (int i = 0; i < 3; i++) cycle("pre-rst", 0, 1, 0, 0, 16'h0);
        ld = 0; sh = 0; r0 = 0;
        #2 reset = 1'b0;
        #1;
        check("async rst r", 32'(out_r), 32'h0);
        check("async rst msb", 32'(out_msb), 32'h0);
        check("async rst cnt", 32'(count), 32'h0);
        check("async rst done", 32'(done), 32'h0);
        m_r = '0; m_msb = '0; m_cnt = '0;
        @(posedge clk);
        #1 reset = 1'b1;
        cycle("post-rst ld", 1, 0, 0, 0, 16'hC003);
        cycle("post-rst sh", 0, 1, 0, 0, 16'h0);

        // STEP=1: done only after the 16th shift
        cycle1(1, 0, 16'hFFFF);
        check("s1 ld cnt", 32'(count1), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            cycle1(0, 1, 16'h0);
            check("s1 cnt", 32'(count1), 32'(i));
            check("s1 done", 32'(done1), 32'(i == 16));
        end
        check("s1 r", 32'(out_r1), 32'h0);
        check("s1 msb", 32'(out_msb1), 32'h1);
        cycle1(0, 1, 16'h0);
        check("s1 sat cnt", 32'(count1), 32'd16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
